// File: rtl/acs_step_sched.sv
// Viterbi trellis-step scheduler: walks NUM_GRP ACS groups per accepted symbol pair.
// Optional path-metric normalization is built only when ACS_NORM_EN is defined.
module acs_step_sched #(
  parameter int NUM_STATES  = 64,
  parameter int NUM_ACS     = 8,
  parameter int PM_W        = 8,
  parameter int TB_DEPTH    = 32,
  parameter int NORM_THRESH = 128,
  localparam int NUM_GRP    = NUM_STATES / NUM_ACS,
  localparam int GRP_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
  localparam int TB_W       = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [1:0]       rx_pair,
  output logic             rx_ready,
  output logic [1:0]       bmc_rx_pair,
  output logic             acs_en,
  output logic [GRP_W-1:0] grp_idx,
  output logic             pm_bank_sel,
  input  logic [PM_W-1:0]  pm_min_in,
  output logic [PM_W-1:0]  norm_sub,
  output logic             sv_we,
  output logic [TB_W-1:0]  sv_addr,
  output logic             step_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   last_grp;

  assign xfer     = rx_valid && rx_ready;
  assign last_grp = (grp_idx == GRP_W'(NUM_GRP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer) state_nxt = RUN;
      RUN:     if (last_grp) state_nxt = FINISH;
      FINISH:  state_nxt = xfer ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so a reset step never looks acceptable.
  always_comb begin
    rx_ready  = rst_n && (state != RUN);
    acs_en    = (state == RUN);
    sv_we     = (state == RUN);
    step_done = (state == FINISH);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmc_rx_pair <= '0;
      grp_idx     <= '0;
      pm_bank_sel <= 1'b0;
      sv_addr     <= '0;
    end else begin
      if (xfer) bmc_rx_pair <= rx_pair;
      unique case (state)
        IDLE: if (xfer) grp_idx <= '0;
        RUN:  grp_idx <= last_grp ? '0 : grp_idx + GRP_W'(1);
        FINISH: begin
          grp_idx     <= '0;
          pm_bank_sel <= ~pm_bank_sel;
          sv_addr     <= sv_addr + TB_W'(1);
        end
        default: grp_idx <= '0;
      endcase
    end
  end

`ifdef ACS_NORM_EN
  logic [PM_W-1:0] run_min;

  // The minimum seen over a step is folded into norm_sub at FINISH and held for the next step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min  <= '1;
      norm_sub <= '0;
    end else begin
      if (xfer)
        run_min <= '1;
      else if ((state == RUN) && (pm_min_in < run_min))
        run_min <= pm_min_in;
      if (state == FINISH)
        norm_sub <= (run_min >= PM_W'(NORM_THRESH)) ? run_min : '0;
    end
  end
`else
  logic unused_norm;

  assign norm_sub    = '0;
  assign unused_norm = ^{pm_min_in, PM_W'(NORM_THRESH)};
`endif

endmodule
